// File: rtl/aurora_tx_framer_if.sv
// FIFO read side and LocalLink TX user side of the Aurora TX framer.
// master = framer, slave = FIFO + LocalLink sink.
interface aurora_tx_framer_if #(
    parameter int DW = 32
);
    logic [DW-1:0] fifo_data_i;
    logic          fifo_empty_i;
    logic          fifo_read_o;
    logic [DW-1:0] tx_d;
    logic          tx_src_rdy_n;
    logic          tx_dst_rdy_n;
    logic          tx_sof_n;
    logic          tx_eof_n;

    modport master (
        input  fifo_data_i, fifo_empty_i, tx_dst_rdy_n,
        output fifo_read_o, tx_d, tx_src_rdy_n, tx_sof_n, tx_eof_n
    );

    modport slave (
        output fifo_data_i, fifo_empty_i, tx_dst_rdy_n,
        input  fifo_read_o, tx_d, tx_src_rdy_n, tx_sof_n, tx_eof_n
    );
endinterface

// File: rtl/aurora_tx_framer.sv
// Pops words from a 1-cycle-latency FIFO and emits FRAME_LEN-word LocalLink frames
// with SOF/EOF, honouring back-pressure and aborting cleanly when the channel drops.
module aurora_tx_framer #(
    parameter int DW        = 32,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 user_clk,
    input  logic                 rst_n,
    input  logic                 channel_up,
    aurora_tx_framer_if.master   bus,
    output logic [CNT_W-1:0]     frames_sent_o,
    output logic [7:0]           aborts_o
);
    localparam int WC_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0] LAST = WC_W'(FRAME_LEN - 1);

    typedef enum logic {DOWN, RUN} state_t;

    state_t            state_q, state_d;
    logic [DW-1:0]     q0_q, q1_q, q0_d, q1_d;
    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0]  frames_q, frames_d;
    logic [7:0]        aborts_q, aborts_d;

    logic              src_vld;
    logic              xfer;
    logic              wr;
    logic              rd;
    logic              head_slot;
    logic [2:0]        pending;

    always_comb begin
        state_d  = state_q;
        q0_d     = q0_q;
        q1_d     = q1_q;
        occ_d    = occ_q;
        wcnt_d   = wcnt_q;
        frames_d = frames_q;
        aborts_d = aborts_q;

        src_vld   = (state_q == RUN) && (occ_q != 2'd0);
        xfer      = src_vld && !bus.tx_dst_rdy_n;
        pending   = {1'b0, occ_q} + {2'b0, inflight_q} - {2'b0, xfer};
        rd        = rst_n && (state_q == RUN) && channel_up && !bus.fifo_empty_i
                    && (pending < 3'd2);
        wr        = inflight_q && (state_q == RUN) && channel_up;
        // Incoming word lands at the head if the queue is empty after this cycle's pop.
        head_slot = (occ_q == 2'd0) || ((occ_q == 2'd1) && xfer);

        unique case (state_q)
            DOWN: begin
                if (channel_up) state_d = RUN;
            end
            RUN: begin
                if (!channel_up) begin
                    // Channel loss takes priority over any handshake in this cycle.
                    state_d = DOWN;
                    q0_d    = '0;
                    q1_d    = '0;
                    occ_d   = 2'd0;
                    wcnt_d  = '0;
                    if ((wcnt_q != '0) && (aborts_q != '1)) aborts_d = aborts_q + 8'd1;
                end else begin
                    if (xfer) begin
                        q0_d = q1_q;
                        if (wcnt_q == LAST) begin
                            wcnt_d   = '0;
                            frames_d = frames_q + CNT_W'(1);
                        end else begin
                            wcnt_d = wcnt_q + WC_W'(1);
                        end
                    end
                    if (wr) begin
                        if (head_slot) q0_d = bus.fifo_data_i;
                        else           q1_d = bus.fifo_data_i;
                    end
                    occ_d = occ_q + {1'b0, wr} - {1'b0, xfer};
                end
            end
            default: state_d = DOWN;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (!rst_n) begin
            state_q    <= DOWN;
            q0_q       <= '0;
            q1_q       <= '0;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            wcnt_q     <= '0;
            frames_q   <= '0;
            aborts_q   <= '0;
        end else begin
            state_q    <= state_d;
            q0_q       <= q0_d;
            q1_q       <= q1_d;
            occ_q      <= occ_d;
            inflight_q <= rd;
            wcnt_q     <= wcnt_d;
            frames_q   <= frames_d;
            aborts_q   <= aborts_d;
        end
    end

    assign bus.fifo_read_o  = rd;
    assign bus.tx_d         = q0_q;
    assign bus.tx_src_rdy_n = !src_vld;
    assign bus.tx_sof_n     = !(src_vld && (wcnt_q == '0));
    assign bus.tx_eof_n     = !(src_vld && (wcnt_q == LAST));
    assign frames_sent_o    = frames_q;
    assign aborts_o         = aborts_q;

endmodule

// File: tb/tb_aurora_tx_framer.sv
// Bench for aurora_tx_framer: three instances (FRAME_LEN 4, 256, 1) fed from array FIFOs,
// received words compared against frame rules computed from word position.
module tb_aurora_tx_framer;
    localparam int N = 3;

    logic        clk;
    logic        rst_n;
    logic        chup   [N];
    logic        dst_n  [N];
    logic [31:0] fdata  [N];
    logic        emp    [N];
    logic        rd     [N];
    logic        src_n  [N];
    logic        sof_n  [N];
    logic        eof_n  [N];
    logic [31:0] txd    [N];
    logic [15:0] fs     [N];
    logic [7:0]  ab     [N];

    logic [31:0] fmem [N][1024];
    int          wp [N];
    int          rp [N];
    int          dst_mode [N];

    typedef struct {
        int          d;
        logic [31:0] data;
        bit          sof;
        bit          eof;
        int          cyc;
    } rx_t;

    rx_t rxq [$];
    int  rxcnt [N];
    int  badrd;
    int  cyc;
    int  errors;
    int  checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        aurora_tx_framer_if #(.DW(32)) bus ();
        assign bus.fifo_data_i  = fdata[g];
        assign bus.fifo_empty_i = emp[g];
        assign bus.tx_dst_rdy_n = dst_n[g];
        assign emp[g]   = (wp[g] == rp[g]);
        assign rd[g]    = bus.fifo_read_o;
        assign src_n[g] = bus.tx_src_rdy_n;
        assign sof_n[g] = bus.tx_sof_n;
        assign eof_n[g] = bus.tx_eof_n;
        assign txd[g]   = bus.tx_d;

        aurora_tx_framer #(
            .DW(32),
            .FRAME_LEN((g == 0) ? 4 : ((g == 1) ? 256 : 1)),
            .CNT_W(16)
        ) dut (
            .user_clk(clk),
            .rst_n(rst_n),
            .channel_up(chup[g]),
            .bus(bus),
            .frames_sent_o(fs[g]),
            .aborts_o(ab[g])
        );
    end

    // One clock: sample handshakes mid-cycle, then act as FIFO and sink after the edge.
    task automatic tick();
        logic r [N];
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            r[d] = rd[d];
            if (rd[d] && (emp[d] || !rst_n)) badrd++;
            if (rst_n && !src_n[d] && !dst_n[d]) begin
                rxq.push_back('{d, txd[d], !sof_n[d], !eof_n[d], cyc});
                rxcnt[d]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < N; d++) begin
            if (r[d] && !emp[d]) begin
                fdata[d] = fmem[d][rp[d]];
                rp[d]++;
            end
            case (dst_mode[d])
                0:       dst_n[d] = 1'b0;
                1:       dst_n[d] = ~dst_n[d];
                default: dst_n[d] = 1'b1;
            endcase
        end
    endtask

    task automatic push(input int d, input logic [31:0] v);
        fmem[d][wp[d]] = v;
        wp[d]++;
    endtask

    task automatic wait_rx(input int d, input int n, input int budget, output bit to);
        int b;
        b = 0;
        while (rxcnt[d] < n && b < budget) begin
            tick();
            b++;
        end
        to = (rxcnt[d] < n);
    endtask

    task automatic start_test(input int act);
        for (int d = 0; d < N; d++) begin
            chup[d]     = 1'b0;
            dst_mode[d] = 2;
            dst_n[d]    = 1'b1;
            rxcnt[d]    = 0;
            rp[d]       = wp[d];
        end
        rxq.delete();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chup[act]     = 1'b1;
        dst_mode[act] = 0;
        dst_n[act]    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < N; d++) begin
            chup[d] = 1'b1;
            dst_mode[d] = 0;
            dst_n[d] = 1'b0;
            push(d, 32'hA5A5_0000 + d);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int d = 0; d < N; d++) begin
                checks++;
                if (rd[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read[%0d] got %b exp 0", d, rd[d]);
                end
            end
        end
        for (int d = 0; d < N; d++) begin
            checks++;
            if ({src_n[d], sof_n[d], eof_n[d]} !== 3'b111) begin
                errors++;
                $display("FAIL reset_flags[%0d] got %b exp 111", d, {src_n[d], sof_n[d], eof_n[d]});
            end
            checks++;
            if (txd[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset_txd[%0d] got %h exp 0", d, txd[d]);
            end
            checks++;
            if (fs[d] !== 16'h0 || ab[d] !== 8'h0) begin
                errors++;
                $display("FAIL reset_cnt[%0d] got fs=%0d ab=%0d exp 0/0", d, fs[d], ab[d]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_frame4();
        bit to;
        start_test(0);
        for (int i = 0; i < 8; i++) push(0, 32'(i + 1));
        wait_rx(0, 8, 100, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL f4_timeout got %0d words exp 8", rxcnt[0]);
        end
        for (int i = 0; i < rxq.size() && i < 8; i++) begin
            checks++;
            if (rxq[i].data !== 32'(i + 1) || rxq[i].sof !== (i % 4 == 0) || rxq[i].eof !== (i % 4 == 3)) begin
                errors++;
                $display("FAIL f4_word[%0d] got %h sof=%b eof=%b exp %h sof=%b eof=%b",
                         i, rxq[i].data, rxq[i].sof, rxq[i].eof, i + 1, i % 4 == 0, i % 4 == 3);
            end
            if (i > 0) begin
                checks++;
                if (rxq[i].cyc !== rxq[i-1].cyc + 1) begin
                    errors++;
                    $display("FAIL f4_gap[%0d] got cyc %0d exp %0d", i, rxq[i].cyc, rxq[i-1].cyc + 1);
                end
            end
        end
        checks++;
        if (fs[0] !== 16'd2) begin
            errors++;
            $display("FAIL f4_frames got %0d exp 2", fs[0]);
        end
    endtask

    task automatic test_back_pressure();
        bit to;
        logic [31:0] exp_w [256];
        start_test(1);
        dst_mode[1] = 1;
        for (int i = 0; i < 256; i++) begin
            exp_w[i] = $urandom;
            push(1, exp_w[i]);
        end
        wait_rx(1, 256, 3000, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL bp_timeout got %0d words exp 256", rxcnt[1]);
        end
        for (int i = 0; i < rxq.size() && i < 256; i++) begin
            checks++;
            if (rxq[i].data !== exp_w[i] || rxq[i].sof !== (i == 0) || rxq[i].eof !== (i == 255)) begin
                errors++;
                $display("FAIL bp_word[%0d] got %h sof=%b eof=%b exp %h sof=%b eof=%b",
                         i, rxq[i].data, rxq[i].sof, rxq[i].eof, exp_w[i], i == 0, i == 255);
            end
        end
        tick();
        checks++;
        if (fs[1] !== 16'd1 || rxcnt[1] !== 256) begin
            errors++;
            $display("FAIL bp_frames got fs=%0d words=%0d exp 1/256", fs[1], rxcnt[1]);
        end
        checks++;
        if (badrd !== 0) begin
            errors++;
            $display("FAIL bp_read_empty got %0d exp 0", badrd);
        end
    endtask

    task automatic test_underrun();
        bit to;
        start_test(0);
        push(0, 32'h11);
        push(0, 32'h22);
        wait_rx(0, 2, 50, to);
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (src_n[0] !== 1'b1) begin
                errors++;
                $display("FAIL ur_gap[%0d] got src_rdy_n=%b exp 1", k, src_n[0]);
            end
        end
        push(0, 32'h33);
        push(0, 32'h44);
        wait_rx(0, 4, 50, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL ur_timeout got %0d words exp 4", rxcnt[0]);
        end else begin
            checks++;
            if (rxq[2].data !== 32'h33 || rxq[2].sof || rxq[2].eof) begin
                errors++;
                $display("FAIL ur_word3 got %h sof=%b eof=%b exp 33 0 0", rxq[2].data, rxq[2].sof, rxq[2].eof);
            end
            checks++;
            if (rxq[3].data !== 32'h44 || rxq[3].sof || !rxq[3].eof) begin
                errors++;
                $display("FAIL ur_word4 got %h sof=%b eof=%b exp 44 0 1", rxq[3].data, rxq[3].sof, rxq[3].eof);
            end
        end
        checks++;
        if (fs[0] !== 16'd1) begin
            errors++;
            $display("FAIL ur_frames got %0d exp 1", fs[0]);
        end
    endtask

    task automatic test_channel_drop();
        bit to;
        logic [31:0] held;
        start_test(0);
        for (int i = 0; i < 6; i++) push(0, 32'h100 + 32'(i));
        wait_rx(0, 2, 50, to);
        dst_mode[0] = 2;
        dst_n[0] = 1'b1;
        tick();
        tick();
        held = txd[0];
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (txd[0] !== held || src_n[0] !== 1'b0 || sof_n[0] !== 1'b1 || eof_n[0] !== 1'b1) begin
                errors++;
                $display("FAIL cd_hold[%0d] got %h src=%b sof=%b eof=%b exp %h 0 1 1",
                         k, txd[0], src_n[0], sof_n[0], eof_n[0], held);
            end
        end
        chup[0] = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (ab[0] !== 8'd1 || src_n[0] !== 1'b1 || rxcnt[0] !== 2) begin
            errors++;
            $display("FAIL cd_abort got ab=%0d src=%b words=%0d exp 1 1 2", ab[0], src_n[0], rxcnt[0]);
        end
        chup[0] = 1'b1;
        dst_mode[0] = 0;
        dst_n[0] = 1'b0;
        wait_rx(0, 3, 50, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL cd_timeout got %0d words exp 3", rxcnt[0]);
        end else begin
            checks++;
            if (rxq[2].data !== 32'h104 || !rxq[2].sof) begin
                errors++;
                $display("FAIL cd_resume got %h sof=%b exp 104 sof=1", rxq[2].data, rxq[2].sof);
            end
        end
        checks++;
        if (fs[0] !== 16'd0) begin
            errors++;
            $display("FAIL cd_frames got %0d exp 0", fs[0]);
        end
    endtask

    task automatic test_frame1();
        bit to;
        start_test(2);
        for (int i = 0; i < 3; i++) push(2, 32'hC0 + 32'(i));
        wait_rx(2, 3, 50, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL f1_timeout got %0d words exp 3", rxcnt[2]);
        end
        for (int i = 0; i < rxq.size() && i < 3; i++) begin
            checks++;
            if (rxq[i].data !== 32'hC0 + 32'(i) || !rxq[i].sof || !rxq[i].eof) begin
                errors++;
                $display("FAIL f1_word[%0d] got %h sof=%b eof=%b exp %h 1 1",
                         i, rxq[i].data, rxq[i].sof, rxq[i].eof, 32'hC0 + 32'(i));
            end
        end
        checks++;
        if (fs[2] !== 16'd3) begin
            errors++;
            $display("FAIL f1_frames got %0d exp 3", fs[2]);
        end
    endtask

    task automatic test_reset_midframe();
        bit to;
        int n0;
        start_test(0);
        for (int i = 0; i < 7; i++) push(0, 32'h200 + 32'(i));
        wait_rx(0, 2, 50, to);
        dst_mode[0] = 2;
        dst_n[0] = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({src_n[0], sof_n[0], eof_n[0], rd[0]} !== 4'b1110 || txd[0] !== 32'h0) begin
            errors++;
            $display("FAIL rm_outputs got src=%b sof=%b eof=%b rd=%b txd=%h exp 1 1 1 0 0",
                     src_n[0], sof_n[0], eof_n[0], rd[0], txd[0]);
        end
        checks++;
        if (fs[0] !== 16'd0 || ab[0] !== 8'd0) begin
            errors++;
            $display("FAIL rm_counters got fs=%0d ab=%0d exp 0/0", fs[0], ab[0]);
        end
        n0 = rxcnt[0];
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (rxcnt[0] !== n0) begin
            errors++;
            $display("FAIL rm_spurious got %0d words exp %0d", rxcnt[0], n0);
        end
        dst_mode[0] = 0;
        dst_n[0] = 1'b0;
        wait_rx(0, 3, 50, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL rm_timeout got %0d words exp 3", rxcnt[0]);
        end else begin
            checks++;
            if (rxq[2].data !== 32'h204 || !rxq[2].sof) begin
                errors++;
                $display("FAIL rm_resume got %h sof=%b exp 204 sof=1", rxq[2].data, rxq[2].sof);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        badrd  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        for (int d = 0; d < N; d++) begin
            chup[d] = 1'b0;
            dst_n[d] = 1'b1;
            dst_mode[d] = 2;
            fdata[d] = '0;
            wp[d] = 0;
            rp[d] = 0;
            rxcnt[d] = 0;
        end
        test_reset();
        test_frame4();
        test_back_pressure();
        test_underrun();
        test_channel_drop();
        test_frame1();
        test_reset_midframe();
        checks++;
        if (badrd !== 0) begin
            errors++;
            $display("FAIL read_while_empty got %0d exp 0", badrd);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got still running exp finished");
        $fatal(1, "timeout");
    end

endmodule
